// File: rtl/alu_regfile_seq.sv
// Parametrised ALU + register file with valid/ready handshake and sticky z/c/v flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 6); otherwise op 6 is an illegal NOP.
module alu_regfile_seq #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RIW   = $clog2(NREGS),
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   params,
    input  logic [RIW-1:0]   src1,
    input  logic [RIW-1:0]   src2,
    input  logic [RIW-1:0]   dst,
    input  logic             use_din,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    input  logic             clr_flags,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_LOGIC = 3'd3,
        OP_SHL = 3'd4, OP_SHR = 3'd5, OP_MUL = 3'd6, OP_LOAD = 3'd7
    } op_e;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

    state_e           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] op1, op2, wr_data;
    logic [WIDTH:0]   addsub;
    logic [RIW-1:0]   wr_addr;
    logic             wr_en, c_set, v_set, accept;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_p, mul_next;
    logic [WIDTH-1:0]   mul_mcand;
    logic [WIDTH:0]     mul_sum;
    logic [RIW-1:0]     mul_dst;
    logic [SHW-1:0]     mul_cnt;
    logic               mul_last;

    // mul_p = {partial high half, multiplier bits not yet consumed}; one bit retired per cycle
    assign mul_sum  = {1'b0, mul_p[2*WIDTH-1:WIDTH]} + (mul_p[0] ? {1'b0, mul_mcand} : '0);
    assign mul_next = {mul_sum, mul_p[WIDTH-1:1]};
    assign mul_last = (mul_cnt == SHW'(WIDTH-1));
`endif

    assign op_ready = (state == S_IDLE) & ~RST;
    assign accept   = op_valid & op_ready;
    assign dout     = regs[src1];
    assign op1      = regs[src1];
    assign op2      = use_din ? din : regs[src2];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dst;
        wr_data = '0;
        c_set   = 1'b0;
        v_set   = 1'b0;
        addsub  = '0;
        if (accept) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    addsub  = (op == OP_ADD) ? {1'b0, op1} + {1'b0, op2} : {1'b0, op1} - {1'b0, op2};
                    wr_en   = 1'b1;
                    wr_data = addsub[WIDTH-1:0];
                    c_set   = addsub[WIDTH];
                    v_set   = addsub[WIDTH];
                end
                OP_LOGIC: begin
                    wr_en = 1'b1;
                    case (params[1:0])
                        2'd0:    wr_data = op1 & op2;
                        2'd1:    wr_data = op1 | op2;
                        2'd2:    wr_data = op1 ^ op2;
                        default: wr_data = ~op1;
                    endcase
                end
                OP_SHL:  begin wr_en = 1'b1; wr_data = op1 << params; end
                OP_SHR:  begin wr_en = 1'b1; wr_data = op1 >> params; end
                OP_LOAD: begin wr_en = 1'b1; wr_data = din; end
`ifndef ALU_MUL_EN
                OP_MUL:  v_set = 1'b1;
`endif
                default: ;
            endcase
        end
`ifdef ALU_MUL_EN
        if (state == S_MUL && mul_last) begin
            wr_en   = 1'b1;
            wr_addr = mul_dst;
            wr_data = mul_next[WIDTH-1:0];
            v_set   = |mul_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            state  <= S_IDLE;
            done   <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
`ifdef ALU_MUL_EN
            mul_p     <= '0;
            mul_mcand <= '0;
            mul_dst   <= '0;
            mul_cnt   <= '0;
`endif
        end else begin
            done   <= wr_en;
            // clear happens before this cycle's contribution is ORed in
            flag_c <= (flag_c & ~clr_flags) | c_set;
            flag_v <= (flag_v & ~clr_flags) | v_set;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                flag_z        <= (wr_data == '0);
            end
`ifdef ALU_MUL_EN
            case (state)
                S_IDLE: if (accept && op == OP_MUL) begin
                    state     <= S_MUL;
                    mul_p     <= {{WIDTH{1'b0}}, op2};
                    mul_mcand <= op1;
                    mul_dst   <= dst;
                    mul_cnt   <= '0;
                end
                S_MUL: begin
                    mul_p   <= mul_next;
                    mul_cnt <= mul_cnt + SHW'(1);
                    if (mul_last) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Randomised bench for alu_regfile_seq (WIDTH=16, NREGS=8) against an arithmetic reference model.
// Follows ALU_MUL_EN the same way as the design build.
module tb_alu_regfile_seq;

    logic        CLK = 1'b0, RST = 1'b1, op_valid = 1'b0, op_ready;
    logic [2:0]  op = '0, src1 = '0, src2 = '0, dst = '0;
    logic [3:0]  params = '0;
    logic        use_din = 1'b0, clr_flags = 1'b0, done, flag_z, flag_c, flag_v;
    logic [15:0] din = '0, dout;

    int n_cmp = 0, n_err = 0;

    logic [15:0] m_regs [8];
    bit          m_c, m_v, m_z;

    alu_regfile_seq #(.WIDTH(16), .NREGS(8)) dut (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .params(params), .src1(src1), .src2(src2), .dst(dst), .use_din(use_din),
        .din(din), .dout(dout), .done(done), .clr_flags(clr_flags),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] r);
        src1 = r;
        #1 chk(tag, {16'b0, dout}, {16'b0, m_regs[r]});
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_z"}, {31'b0, flag_z}, {31'b0, m_z});
        chk({tag, "_c"}, {31'b0, flag_c}, {31'b0, m_c});
        chk({tag, "_v"}, {31'b0, flag_v}, {31'b0, m_v});
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_c = 0; m_v = 0; m_z = 0;
    endtask

    // Reference effect of an accepted op; wr reports whether a register is written now
    task automatic m_accept(input logic [2:0] o, input logic [3:0] p, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] di, input logic [2:0] d,
                            input bit cl, output bit wr);
        int unsigned r = 0;
        bit c = 0, v = 0;
        wr = 1;
        if (cl) begin m_c = 0; m_v = 0; end
        case (o)
            3'd0: wr = 0;
            3'd1: begin r = a + b; c = (r > 32'hFFFF); v = c; end
            3'd2: begin r = a - b; c = (a < b); v = c; end
            3'd3: case (p[1:0])
                      2'd0: r = a & b;
                      2'd1: r = a | b;
                      2'd2: r = a ^ b;
                      default: r = ~a;
                  endcase
            3'd4: r = a << p;
            3'd5: r = a >> p;
            3'd6: begin
                wr = 0;
`ifndef ALU_MUL_EN
                v = 1;
`endif
            end
            default: r = di;
        endcase
        m_c = m_c | c;
        m_v = m_v | v;
        if (wr) begin
            m_regs[d] = r[15:0];
            m_z = (r[15:0] == 16'h0);
        end
    endtask

    task automatic m_mul_done(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        longint unsigned prod = longint'(a) * longint'(b);
        m_regs[d] = prod[15:0];
        m_v = m_v | (prod > 64'hFFFF);
        m_z = (prod[15:0] == 16'h0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [3:0] p, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d, input bit ud,
                         input logic [15:0] di, input bit cl);
        logic [15:0] a, b;
        bit wr;
        int k, rl;
        @(negedge CLK);
        op = o; params = p; src1 = s1; src2 = s2; dst = d; use_din = ud; din = di;
        clr_flags = cl; op_valid = 1'b1;
        k = 0;
        while (!op_ready && k < 50) begin @(negedge CLK); k++; end
        if (!op_ready) begin
            chk("ready_timeout", 0, 1);
            op_valid = 1'b0;
            return;
        end
        a = m_regs[s1];
        b = ud ? di : m_regs[s2];
        m_accept(o, p, a, b, di, d, cl, wr);
        @(negedge CLK);
        op_valid = 1'b0;
        clr_flags = 1'b0;
`ifdef ALU_MUL_EN
        if (o == 3'd6) begin
            rl = 0; k = 1;
            while (!done && k < 40) begin
                if (!op_ready) rl++;
                @(negedge CLK);
                k++;
            end
            chk("mul_latency", k, 17);
            chk("mul_ready_low", rl, 16);
            m_mul_done(a, b, d);
        end else
`endif
        chk("done", {31'b0, done}, {31'b0, wr});
        chk_flags("flags");
        rd_chk("wr_reg", d);
    endtask

    initial begin
        logic [2:0]  ro, rs1, rs2, rd;
        logic [3:0]  rp;
        logic [15:0] rdi, ma;
        bit          rud, rcl, wr;
        int          k, seen;

        m_reset();
        repeat (2) @(negedge CLK);
        chk("rst_ready_low", {31'b0, op_ready}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk_flags("rst_flags");
        RST = 1'b0;
        #1 chk("ready_after_rst", {31'b0, op_ready}, 1);
        for (int r = 0; r < 8; r++) rd_chk("rst_reg", 3'(r));

        // LOAD FFFF then ADD +1 wraps to zero with carry
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b0);
        issue(3'd1, 4'd0, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0001, 1'b0);
        src1 = 3'd1;
        #1 chk("add_wrap_r1", {16'b0, dout}, 0);
        chk("add_wrap_z", {31'b0, flag_z}, 1);
        chk("add_wrap_c", {31'b0, flag_c}, 1);
        chk("add_wrap_v", {31'b0, flag_v}, 1);

        // SUB 5-7 borrows; clear comes with the first LOAD
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd2, 1'b0, 16'd5, 1'b1);
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd3, 1'b0, 16'd7, 1'b0);
        issue(3'd2, 4'd0, 3'd2, 3'd3, 3'd4, 1'b0, 16'd0, 1'b0);
        src1 = 3'd4;
        #1 chk("sub_borrow_val", {16'b0, dout}, 32'hFFFE);
        chk("sub_borrow_c", {31'b0, flag_c}, 1);
        issue(3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b1);
        chk("clr_c", {31'b0, flag_c}, 0);
        chk("clr_v", {31'b0, flag_v}, 0);

        // shifts at extreme amounts; flags carried through unchanged
        issue(3'd2, 4'd0, 3'd2, 3'd3, 3'd7, 1'b0, 16'd0, 1'b0);
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0001, 1'b0);
        issue(3'd4, 4'd15, 3'd0, 3'd0, 3'd5, 1'b0, 16'd0, 1'b0);
        issue(3'd5, 4'd4, 3'd5, 3'd0, 3'd6, 1'b0, 16'd0, 1'b0);
        src1 = 3'd5;
        #1 chk("shl15", {16'b0, dout}, 32'h8000);
        src1 = 3'd6;
        #1 chk("shr4", {16'b0, dout}, 32'h0800);
        chk("shift_keeps_c", {31'b0, flag_c}, 1);

`ifdef ALU_MUL_EN
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd5, 1'b0, 16'd300, 1'b1);
        issue(3'd6, 4'd0, 3'd5, 3'd5, 3'd6, 1'b0, 16'd0, 1'b0);
        src1 = 3'd6;
        #1 chk("mul300", {16'b0, dout}, 32'h5F90);
        chk("mul300_v", {31'b0, flag_v}, 1);

        // a held request during MUL is taken only once ready returns
        @(negedge CLK);
        op = 3'd6; src1 = 3'd5; src2 = 3'd5; dst = 3'd7; use_din = 1'b0; op_valid = 1'b1;
        ma = m_regs[5];
        m_accept(3'd6, 4'd0, ma, ma, 16'd0, 3'd7, 1'b0, wr);
        @(negedge CLK);
        op = 3'd7; din = 16'h1234; dst = 3'd3;
        k = 1;
        while (!done && k < 40) begin @(negedge CLK); k++; end
        chk("hold_mul_latency", k, 17);
        m_mul_done(ma, ma, 3'd7);
        rd_chk("hold_not_taken", 3'd3);
        m_accept(3'd7, 4'd0, 16'd0, 16'd0, 16'h1234, 3'd3, 1'b0, wr);
        @(negedge CLK);
        op_valid = 1'b0;
        chk("hold_done", {31'b0, done}, 1);
        rd_chk("hold_load", 3'd3);
        rd_chk("hold_mul", 3'd7);
        chk_flags("hold_flags");

        // reset mid-multiply aborts without a write or done
        @(negedge CLK);
        op = 3'd6; src1 = 3'd5; src2 = 3'd5; dst = 3'd4; op_valid = 1'b1;
        @(negedge CLK);
        op_valid = 1'b0;
        seen = 0;
        repeat (7) begin if (done) seen++; @(negedge CLK); end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_reset();
        #1 chk("abort_ready", {31'b0, op_ready}, 1);
        repeat (20) begin if (done) seen++; @(negedge CLK); end
        chk("abort_no_done", seen, 0);
        rd_chk("abort_dst", 3'd4);
        chk_flags("abort_flags");
`else
        issue(3'd7, 4'd0, 3'd0, 3'd0, 3'd6, 1'b0, 16'h1111, 1'b0);
        issue(3'd6, 4'd0, 3'd6, 3'd6, 3'd6, 1'b0, 16'd0, 1'b1);
        src1 = 3'd6;
        #1 chk("illegal_mul_nowrite", {16'b0, dout}, 32'h1111);
        chk("illegal_mul_v", {31'b0, flag_v}, 1);
`endif

        for (int i = 0; i < 300; i++) begin
            ro  = 3'($urandom_range(7));
            rp  = 4'($urandom_range(15));
            rs1 = 3'($urandom_range(7));
            rs2 = 3'($urandom_range(7));
            rd  = 3'($urandom_range(7));
            rud = 1'($urandom_range(1));
            rdi = 16'($urandom);
            if ($urandom_range(3) == 0) rdi = ($urandom_range(1) == 1) ? 16'hFFFF : 16'h0000;
            rcl = ($urandom_range(7) == 0);
            issue(ro, rp, rs1, rs2, rd, rud, rdi, rcl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
